// File: rtl/mips_dmem_responder.sv
// Data-side memory responder for the MIPS CPU: big-endian word RAM with byte lanes, and an MMIO TX FIFO plus status.
// Define MIPS_DMEM_CYCLE_COUNTER_EN to add a writable 32-bit cycle counter at MMIO offset 0x0008.
module mips_dmem_responder #(
   parameter int          ADDR_WIDTH = 10,
   parameter int          FIFO_DEPTH = 8,
   parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic [3:0]  mem_write_en,
   input  logic        mem_read_en,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_write_data,
   output logic [31:0] mem_read_data,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   localparam logic [15:0] OFF_TX_DATA   = 16'h0000;
   localparam logic [15:0] OFF_TX_STATUS = 16'h0004;
   localparam logic [15:0] OFF_CYCLE     = 16'h0008;

   logic                  is_mmio;
   logic [15:0]           mmio_off;
   logic                  any_we;
   logic [ADDR_WIDTH-1:0] word_idx;
   logic                  ram_we;

   logic [31:0]           ram [0:(2**ADDR_WIDTH)-1];
   logic [31:0]           mmio_rdata;

   logic [7:0]            fifo_mem [0:FIFO_DEPTH-1];
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic [CNT_W-1:0]      fifo_count;
   logic [7:0]            count8;
   logic                  fifo_empty;
   logic                  fifo_full;
   logic                  push_req;
   logic                  push;
   logic                  pop;
   logic                  status_wr;
   logic                  overflow;

   assign is_mmio  = (mem_addr[31:16] == MMIO_BASE[31:16]);
   assign mmio_off = mem_addr[15:0];
   assign any_we   = |mem_write_en;
   assign word_idx = mem_addr[ADDR_WIDTH+1:2];
   assign ram_we   = en & ~is_mmio & any_we;

   // Lane i covers bits 8*i+7:8*i, so enable bit 3 lands on the big-endian byte at offset 0.
   always_ff @(posedge clk) begin
      if (ram_we) begin
         for (int lane = 0; lane < 4; lane++) begin
            if (mem_write_en[lane]) begin
               ram[word_idx][8*lane +: 8] <= mem_write_data[8*lane +: 8];
            end
         end
      end
   end

   assign fifo_empty = (fifo_count == '0);
   assign fifo_full  = (fifo_count == CNT_W'(FIFO_DEPTH));
   assign count8     = 8'(fifo_count);
   assign push_req   = en & is_mmio & any_we & (mmio_off == OFF_TX_DATA);
   assign status_wr  = en & is_mmio & any_we & (mmio_off == OFF_TX_STATUS);
   assign pop        = ~fifo_empty & tx_ready;
   assign push       = push_req & (~fifo_full | pop);

   assign tx_valid = ~fifo_empty;
   assign tx_data  = fifo_empty ? 8'h00 : fifo_mem[rd_ptr];

`ifdef MIPS_DMEM_CYCLE_COUNTER_EN
   logic [31:0] cycle_count;
   logic        cycle_wr;

   assign cycle_wr = is_mmio & any_we & (mmio_off == OFF_CYCLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cycle_count <= '0;
      end else if (en) begin
         cycle_count <= cycle_wr ? mem_write_data : cycle_count + 32'd1;
      end
   end
`endif

   always_comb begin
      mmio_rdata = '0;
      case (mmio_off)
         OFF_TX_STATUS: mmio_rdata = {16'b0, count8, 5'b0, overflow, fifo_empty, fifo_full};
`ifdef MIPS_DMEM_CYCLE_COUNTER_EN
         OFF_CYCLE:     mmio_rdata = cycle_count;
`endif
         default:       mmio_rdata = '0;
      endcase
   end

   // The RAM read samples the pre-edge word, so a same-cycle store to that word returns old data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_read_data <= '0;
      end else if (en && mem_read_en) begin
         mem_read_data <= is_mmio ? mmio_rdata : ram[word_idx];
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr] <= mem_write_data[7:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + CNT_W'(1);
            2'b01:   fifo_count <= fifo_count - CNT_W'(1);
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   // Overflow is sticky until software writes TX_STATUS; a push that coincides with a pop is never lost.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow <= 1'b0;
      end else if (status_wr) begin
         overflow <= 1'b0;
      end else if (push_req && fifo_full && !pop) begin
         overflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_mips_dmem_responder.sv
// Self-checking bench for mips_dmem_responder: vector table for RAM/MMIO reads plus FIFO, en and reset sequences.
// Expected load data goes through a scoreboard queue; TX bytes are checked against a FIFO model.
module tb_mips_dmem_responder;

   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en;
   logic [3:0]  mem_write_en;
   logic        mem_read_en;
   logic [31:0] mem_addr;
   logic [31:0] mem_write_data;
   logic [31:0] mem_read_data;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;

   int tests = 0;
   int fails = 0;

   logic [31:0] rd_q[$];
   string       rd_name[$];
   logic [7:0]  tx_q[$];

   typedef struct {
      string       name;
      logic [3:0]  we;
      logic        re;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[$];

   mips_dmem_responder dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .en            (en),
      .mem_write_en  (mem_write_en),
      .mem_read_en   (mem_read_en),
      .mem_addr      (mem_addr),
      .mem_write_data(mem_write_data),
      .mem_read_data (mem_read_data),
      .tx_data       (tx_data),
      .tx_valid      (tx_valid),
      .tx_ready      (tx_ready)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %08h, expected %08h", name, act, exp);
      end
   endtask

   // Called just after an edge: model the TX pop/push for the coming edge, then compare any due load.
   task automatic checkOutput(input bit load_issued, input bit push_req, input logic [7:0] push_byte);
      bit          do_pop;
      logic [31:0] exp;
      string       nm;
      do_pop = (tx_q.size() != 0) && (tx_ready === 1'b1);
      if (do_pop) begin
         check("tx_pop_data", {24'h0, tx_data}, {24'h0, tx_q[0]});
         tx_q.delete(0);
      end
      if (push_req && tx_q.size() < DEPTH) begin
         tx_q.push_back(push_byte);
      end
      @(posedge clk);
      #1;
      if (load_issued) begin
         exp = rd_q.pop_front();
         nm  = rd_name.pop_front();
         check(nm, mem_read_data, exp);
      end
   endtask

   task automatic applyStimulus(input string name, input logic [3:0] we, input logic re,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] exp);
      bit ld;
      mem_write_en   = we;
      mem_read_en    = re;
      mem_addr       = addr;
      mem_write_data = wdata;
      ld = (en === 1'b1) && (re === 1'b1);
      if (ld) begin
         rd_q.push_back(exp);
         rd_name.push_back(name);
      end
      checkOutput(ld, (en === 1'b1) && (we != 4'h0) && (addr == 32'hFFFF_0000), wdata[7:0]);
   endtask

   task automatic idle();
      applyStimulus("idle", 4'h0, 1'b0, 32'h0, 32'h0, 32'h0);
   endtask

   task automatic pushByte(input logic [7:0] b);
      applyStimulus("push", 4'hF, 1'b0, 32'hFFFF_0000, {4{b}}, 32'h0);
   endtask

   initial begin
      logic [7:0] b;

      rst_n          = 1'b0;
      en             = 1'b1;
      tx_ready       = 1'b0;
      mem_write_en   = 4'h0;
      mem_read_en    = 1'b0;
      mem_addr       = 32'h0;
      mem_write_data = 32'h0;

      vecs.push_back('{"store_word",      4'hF, 1'b0, 32'h0000_0010, 32'hDEADBEEF, 32'h0});
      vecs.push_back('{"load_word",       4'h0, 1'b1, 32'h0000_0010, 32'h0,        32'hDEADBEEF});
      vecs.push_back('{"store_lane1",     4'h2, 1'b0, 32'h0000_0012, 32'h55555555, 32'h0});
      vecs.push_back('{"load_lane1",      4'h0, 1'b1, 32'h0000_0012, 32'h0,        32'hDEAD55EF});
      vecs.push_back('{"store_14",        4'hF, 1'b0, 32'h0000_0014, 32'hA5A5A5A5, 32'h0});
      vecs.push_back('{"ld_st_same_old",  4'hF, 1'b1, 32'h0000_0014, 32'h11223344, 32'hA5A5A5A5});
      vecs.push_back('{"ld_after_st_new", 4'h8, 1'b1, 32'h0000_0014, 32'h77777777, 32'h11223344});
      vecs.push_back('{"ld_lane3",        4'h1, 1'b1, 32'h0000_0017, 32'h99999999, 32'h77223344});
      vecs.push_back('{"ld_lane0",        4'h0, 1'b1, 32'h0000_0014, 32'h0,        32'h77223399});
      vecs.push_back('{"mmio_unmapped_wr",4'hF, 1'b0, 32'hFFFF_0010, 32'h0,        32'h0});
      vecs.push_back('{"ram_untouched",   4'h0, 1'b1, 32'h0000_0010, 32'h0,        32'hDEAD55EF});
      vecs.push_back('{"addr_alias",      4'h0, 1'b1, 32'h0000_1010, 32'h0,        32'hDEAD55EF});
      vecs.push_back('{"mmio_unmapped_rd",4'h0, 1'b1, 32'hFFFF_0010, 32'h0,        32'h0});
      vecs.push_back('{"tx_data_rd",      4'h0, 1'b1, 32'hFFFF_0000, 32'h0,        32'h0});
      vecs.push_back('{"status_reset",    4'h0, 1'b1, 32'hFFFF_0004, 32'h0,        32'h0000_0002});
`ifndef MIPS_DMEM_CYCLE_COUNTER_EN
      vecs.push_back('{"cycle_wr_ignored",4'hF, 1'b0, 32'hFFFF_0008, 32'h12345678, 32'h0});
      vecs.push_back('{"cycle_rd_zero",   4'h0, 1'b1, 32'hFFFF_0008, 32'h0,        32'h0});
`endif

      repeat (2) @(posedge clk);
      #1;
      check("reset_rd_data", mem_read_data, 32'h0);
      check("reset_tx_valid", {31'b0, tx_valid}, 32'h0);
      check("reset_tx_data", {24'b0, tx_data}, 32'h0);
      rst_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i].name, vecs[i].we, vecs[i].re, vecs[i].addr, vecs[i].wdata, vecs[i].exp);
      end

      // Read data holds across a non-load cycle.
      applyStimulus("hold_pre", 4'h0, 1'b1, 32'h0000_0014, 32'h0, 32'h77223399);
      applyStimulus("hold_idle", 4'h0, 1'b0, 32'h0000_0010, 32'h0, 32'h0);
      check("hold_no_load", mem_read_data, 32'h77223399);

      // Fill past full with the sink stalled.
      for (int i = 0; i < 9; i++) begin
         b = 8'h41 + 8'(i);
         pushByte(b);
      end
      applyStimulus("status_full_ovf", 4'h0, 1'b1, 32'hFFFF_0004, 32'h0, 32'h0000_0805);
      check("head_after_fill", {24'h0, tx_data}, 32'h41);
      check("valid_after_fill", {31'b0, tx_valid}, 32'h1);
      applyStimulus("status_clear", 4'hF, 1'b0, 32'hFFFF_0004, 32'h0, 32'h0);
      applyStimulus("status_cleared", 4'h0, 1'b1, 32'hFFFF_0004, 32'h0, 32'h0000_0801);

      // Drain with alternating back-pressure.
      for (int i = 0; i < 20; i++) begin
         tx_ready = (i % 2 == 0);
         idle();
      end
      tx_ready = 1'b0;
      check("valid_after_drain", {31'b0, tx_valid}, 32'h0);
      applyStimulus("status_drained", 4'h0, 1'b1, 32'hFFFF_0004, 32'h0, 32'h0000_0002);

      // Push and pop together while full.
      for (int i = 0; i < 8; i++) begin
         b = 8'h50 + 8'(i);
         pushByte(b);
      end
      tx_ready = 1'b1;
      pushByte(8'h5A);
      tx_ready = 1'b0;
      applyStimulus("status_pushpop_full", 4'h0, 1'b1, 32'hFFFF_0004, 32'h0, 32'h0000_0801);
      tx_ready = 1'b1;
      repeat (10) idle();
      tx_ready = 1'b0;
      applyStimulus("status_after_5a", 4'h0, 1'b1, 32'hFFFF_0004, 32'h0, 32'h0000_0002);

      // en=0 freezes RAM, read data and pushes.
      applyStimulus("store_20", 4'hF, 1'b0, 32'h0000_0020, 32'h12345678, 32'h0);
      applyStimulus("load_before_en0", 4'h0, 1'b1, 32'h0000_0010, 32'h0, 32'hDEAD55EF);
      en = 1'b0;
      applyStimulus("en0_store_load", 4'hF, 1'b1, 32'h0000_0020, 32'hCAFEF00D, 32'h0);
      check("en0_rd_hold", mem_read_data, 32'hDEAD55EF);
      pushByte(8'h66);
      en = 1'b1;
      applyStimulus("ram_after_en0", 4'h0, 1'b1, 32'h0000_0020, 32'h0, 32'h12345678);
      applyStimulus("status_en0_push", 4'h0, 1'b1, 32'hFFFF_0004, 32'h0, 32'h0000_0002);

      // Pops continue while en=0.
      pushByte(8'h33);
      en       = 1'b0;
      tx_ready = 1'b1;
      idle();
      tx_ready = 1'b0;
      en       = 1'b1;
      check("en0_pop_valid", {31'b0, tx_valid}, 32'h0);

      // Asynchronous reset in mid-cycle with data pending and overflow set.
      for (int i = 0; i < 9; i++) begin
         b = 8'h70 + 8'(i);
         pushByte(b);
      end
      applyStimulus("load_before_rst", 4'h0, 1'b1, 32'h0000_0010, 32'h0, 32'hDEAD55EF);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_tx_valid", {31'b0, tx_valid}, 32'h0);
      check("async_rst_tx_data", {24'b0, tx_data}, 32'h0);
      check("async_rst_rd_data", mem_read_data, 32'h0);
      tx_q.delete();
      #1;
      rst_n = 1'b1;
      applyStimulus("status_after_rst", 4'h0, 1'b1, 32'hFFFF_0004, 32'h0, 32'h0000_0002);

`ifdef MIPS_DMEM_CYCLE_COUNTER_EN
      applyStimulus("cycle_load", 4'hF, 1'b0, 32'hFFFF_0008, 32'h0000_0100, 32'h0);
      applyStimulus("cycle_rd0", 4'h0, 1'b1, 32'hFFFF_0008, 32'h0, 32'h0000_0100);
      repeat (4) idle();
      applyStimulus("cycle_rd5", 4'h0, 1'b1, 32'hFFFF_0008, 32'h0, 32'h0000_0105);
      en = 1'b0;
      repeat (2) idle();
      en = 1'b1;
      applyStimulus("cycle_en0_hold", 4'h0, 1'b1, 32'hFFFF_0008, 32'h0, 32'h0000_0106);
      applyStimulus("cycle_load_max", 4'hF, 1'b0, 32'hFFFF_0008, 32'hFFFF_FFFF, 32'h0);
      applyStimulus("cycle_rd_max", 4'h0, 1'b1, 32'hFFFF_0008, 32'h0, 32'hFFFF_FFFF);
      applyStimulus("cycle_wrap", 4'h0, 1'b1, 32'hFFFF_0008, 32'h0, 32'h0000_0000);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/mips_dmem_responder.md
Name: mips_dmem_responder

Overview:
- Memory-side responder for the MIPS CPU data port. It services loads and stores issued in the CPU's X stage and returns load data one cycle later, in the CPU's M stage.
- Contains a word-addressed, big-endian RAM with per-byte write enables.
- Contains a small MMIO window: a byte-wide TX FIFO drained over a valid/ready stream, plus status registers.
- Sits beside the CPU in the top level, sharing the CPU's clk and en.

Parameters:
- ADDR_WIDTH, 10, RAM depth is 2^ADDR_WIDTH 32-bit words, indexed by mem_addr[ADDR_WIDTH+1:2].
- FIFO_DEPTH, 8, TX FIFO entries (power of 2, ≥2).
- MMIO_BASE, 32'hFFFF_0000, MMIO window is selected when mem_addr[31:16] == MMIO_BASE[31:16].

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- en  in  1  global enable; when low, the CPU-side state (RAM, read register, FIFO push, counter) holds.
- mem_write_en  in  4  byte-lane write enables; bit3 = bits 31:24 = byte address offset 0 (big-endian).
- mem_read_en  in  1  load request this cycle.
- mem_addr  in  32  byte address; bits 1:0 are ignored for RAM indexing.
- mem_write_data  in  32  store data (byte stores arrive replicated across lanes).
- mem_read_data  out  32  load data, registered.
- tx_data  out  8  head byte of the TX FIFO.
- tx_valid  out  1  FIFO not empty.
- tx_ready  in  1  sink accepts tx_data this cycle.

Behaviour:
- Reset (rst_n=0, async):
  - mem_read_data=0, FIFO empty, tx_valid=0, tx_data=0, overflow=0, counter=0.
  - RAM contents are not reset.
- Store (en=1, any mem_write_en bit set, RAM region):
  - Each lane with its enable set writes the matching byte of mem_write_data into the addressed word at the clock edge.
  - Lanes without their enable set are untouched.
- Load (en=1, mem_read_en=1):
  - mem_read_data updates at the next edge with the addressed word (full 32 bits; the CPU does byte selection).
  - Latency is exactly 1 cycle. The value holds until the next load.
- Cycles with en=1 and mem_read_en=0 do not change mem_read_data.
- Simultaneous load and store to the same word in one cycle: mem_read_data returns the old word.
- A load in the cycle after a store to the same word returns the new word.
- MMIO offsets (mem_addr[15:0]):
  - 0x0000 TX_DATA: a write with any enable set pushes mem_write_data[7:0]. Reads return 0.
  - 0x0004 TX_STATUS: reads return {16'b0, count[7:0], 5'b0, overflow, empty, full}. Any write clears overflow.
  - 0x0008 CYCLE: see Optional Feature.
  - Other offsets: reads return 0, writes are ignored.
- MMIO accesses never touch the RAM.
- FIFO:
  - A push is accepted when not full, or when a pop occurs in the same cycle.
  - A push to a full FIFO with no pop is dropped and sets overflow (sticky).
  - Pop occurs when tx_valid & tx_ready. Popping is independent of en.
  - tx_data is the head entry; first word fall-through, so the first push is visible on the next cycle.
  - Pointers wrap modulo FIFO_DEPTH. count ranges 0..FIFO_DEPTH.
  - Simultaneous push and pop: count is unchanged and order is preserved.
- en=0:
  - RAM, mem_read_data, FIFO push, overflow and the counter all hold.
  - FIFO pop continues.
- Reset mid-operation: FIFO contents are discarded immediately and tx_valid drops asynchronously.

Optional Feature:
- Macro: MIPS_DMEM_CYCLE_COUNTER_EN.
- Defined:
  - A 32-bit free-running counter increments every clk with en=1 and wraps at 2^32.
  - Reads at MMIO 0x0008 return the pre-edge counter value (registered like other reads).
  - A write with any enable set loads mem_write_data into the counter.
- Undefined:
  - No counter logic. Offset 0x0008 reads 0 and writes are ignored.

Test Plan:
- Word store then load: write 0xDEADBEEF with enables 4'b1111 to 0x0000_0010; load the next cycle → mem_read_data=0xDEADBEEF one cycle after mem_read_en.
- Byte lanes: on word 0x10=0xDEADBEEF, store 0x55555555 with enables 4'b0010 (address 0x12) → load returns 0xDEAD55EF.
- FIFO fill and overflow (tx_ready=0): push 0x41..0x49 (9 pushes, depth 8) → status read = 0x0000_0805 (count 8, overflow, full). tx_data=0x41. Write status → overflow clears.
- Drain with back-pressure: toggle tx_ready 1,0,1… → bytes 0x41..0x48 emerge in order with no duplicates; the final status read is 0x0000_0002 (empty).
- Simultaneous push/pop at full: FIFO full, tx_ready=1, push 0x5A → count stays 8, overflow stays 0, 0x5A emerges last.
- en=0 hold and async reset: with en=0, issue a store to 0x20 and a load → RAM and mem_read_data are unchanged. Pulse rst_n low mid-cycle → tx_valid=0 and mem_read_data=0 immediately. With the macro defined, the CYCLE readback increases by exactly N over N enabled cycles.
